// File: rtl/chip_tx_serializer.sv
// Parallel-to-serial chip transmitter: sends each accepted word LSB-first, every chip held
// for nb_q clocks, with chip-start / mid-chip / last-chip strobes for the modulator and CDR.
module chip_tx_serializer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 6
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [CNT_W-1:0]  i_nb_P,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_chip,
    output logic              o_chip_start,
    output logic              o_mid,
    output logic              o_last,
    output logic              o_busy
);

    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] MIN_NB   = CNT_W'(4);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   nb_q, nb_d;
    logic [BIT_W-1:0]   bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;

    logic ready_q, ready_d;
    logic chip_q, chip_d;
    logic start_q, start_d;
    logic mid_q, mid_d;
    logic last_q, last_d;
    logic busy_q, busy_d;

    logic             accept;
    logic [CNT_W-1:0] nb_clamped;
    logic             send_d;

    assign accept     = i_valid & ready_q;
    assign nb_clamped = (i_nb_P < MIN_NB) ? MIN_NB : i_nb_P;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        nb_d      = nb_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d   = StSend;
                    shreg_d   = i_data;
                    nb_d      = nb_clamped;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                end
            end
            StSend: begin
                if (cnt_q == nb_q - CNT_W'(1)) begin
                    cnt_d = '0;
                    if (bit_idx_q == LAST_BIT) begin
                        bit_idx_d = '0;
                        // ready_q is high on this clock, so a waiting word chains with no gap
                        if (accept) begin
                            shreg_d = i_data;
                            nb_d    = nb_clamped;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from next-state so they line up with the counters they describe.
    always_comb begin
        send_d  = (state_d == StSend);
        chip_d  = send_d & shreg_d[bit_idx_d];
        start_d = send_d & (cnt_d == '0);
        mid_d   = send_d & (cnt_d == ((nb_d - CNT_W'(1)) >> 1));
        last_d  = send_d & (bit_idx_d == LAST_BIT);
        busy_d  = send_d;
        ready_d = ~send_d | ((cnt_d == nb_d - CNT_W'(1)) & (bit_idx_d == LAST_BIT));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            nb_q      <= MIN_NB;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            ready_q   <= 1'b0;
            chip_q    <= 1'b0;
            start_q   <= 1'b0;
            mid_q     <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            nb_q      <= nb_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            ready_q   <= ready_d;
            chip_q    <= chip_d;
            start_q   <= start_d;
            mid_q     <= mid_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
        end
    end

    assign o_ready      = ready_q;
    assign o_chip       = chip_q;
    assign o_chip_start = start_q;
    assign o_mid        = mid_q;
    assign o_last       = last_q;
    assign o_busy       = busy_q;

endmodule

// File: tb/tb_chip_tx_serializer.sv
// Bench for chip_tx_serializer: per-clock schedule model, directed literal checks and a
// random back-to-back loopback through a mid-chip sampling receiver.
`timescale 1ns/1ps
module tb_chip_tx_serializer;

    localparam int DW = 8;
    localparam int CW = 6;

    logic          i_clk;
    logic          i_rst;
    logic [CW-1:0] i_nb_P;
    logic [DW-1:0] i_data;
    logic          i_valid;
    logic          o_ready, o_chip, o_chip_start, o_mid, o_last, o_busy;

    chip_tx_serializer #(.DATA_W(DW), .CNT_W(CW)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_nb_P       (i_nb_P),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .o_chip       (o_chip),
        .o_chip_start (o_chip_start),
        .o_mid        (o_mid),
        .o_last       (o_last),
        .o_busy       (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_shown = 0;

    // Literal expectations posted by the stimulus, checked by the compare process.
    string lit_nm[$];
    int    lit_act[$];
    int    lit_exp[$];
    int    lit_idx = 0;

    task automatic lit(input string nm, input int act, input int exp);
        lit_nm.push_back(nm);
        lit_act.push_back(act);
        lit_exp.push_back(exp);
    endtask

    // Model: every accepted word expands into its full per-clock output schedule.
    // Entry bits: {chip, start, mid, last, busy, ready}
    logic [5:0]    sched[$];
    logic [5:0]    exp_out = 6'b0;
    logic          last_acc = 1'b0;
    logic          chk_en = 1'b0;
    logic [DW-1:0] tx_words[$];

    always @(posedge i_clk) begin
        logic acc;
        int   nb;
        acc = 1'b0;
        if (i_rst) begin
            sched.delete();
            exp_out <= 6'b0;
        end else begin
            acc = i_valid && exp_out[0];
            if (sched.size() > 0) void'(sched.pop_front());
            if (acc) begin
                nb = (int'(i_nb_P) < 4) ? 4 : int'(i_nb_P);
                for (int k = 0; k < DW * nb; k++) begin
                    sched.push_back({i_data[k / nb], (k % nb) == 0, (k % nb) == (nb - 1) / 2,
                                     (k / nb) == DW - 1, 1'b1, k == DW * nb - 1});
                end
                tx_words.push_back(i_data);
            end
            exp_out <= (sched.size() > 0) ? sched[0] : 6'b000001;
        end
        last_acc <= acc;
        chk_en   <= 1'b1;
    end

    always @(negedge i_clk) begin
        logic [5:0] dut_out;
        dut_out = {o_chip, o_chip_start, o_mid, o_last, o_busy, o_ready};
        if (chk_en) begin
            n_chk++;
            if (dut_out === exp_out) begin
                n_pass++;
            end else if (n_shown < 30) begin
                n_shown++;
                $display("FAIL cycle_cmp t=%0t chip/start/mid/last/busy/ready got %b expected %b",
                         $time, dut_out, exp_out);
            end
        end
        while (lit_idx < lit_act.size()) begin
            n_chk++;
            if (lit_act[lit_idx] == lit_exp[lit_idx]) n_pass++;
            else $display("FAIL %s got %0d expected %0d", lit_nm[lit_idx], lit_act[lit_idx],
                          lit_exp[lit_idx]);
            lit_idx++;
        end
    end

    // Receiver: sample the chip on each mid-chip strobe, word complete on the last chip.
    logic [DW-1:0] rx_sh = '0;
    logic [DW-1:0] rx_words[$];

    always @(negedge i_clk) begin
        if (o_mid === 1'b1) begin
            rx_sh <= {o_chip, rx_sh[DW-1:1]};
            if (o_last === 1'b1) rx_words.push_back({o_chip, rx_sh[DW-1:1]});
        end
    end

    task automatic wait_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_acc();
        int n;
        n = 0;
        do begin
            wait_cycle();
            n++;
        end while (!last_acc && n < 1000);
        if (!last_acc) lit("accept_timeout", 0, 1);
    endtask

    task automatic send(input logic [DW-1:0] d, input int nb);
        i_data  = d;
        i_nb_P  = CW'(nb);
        i_valid = 1'b1;
        wait_acc();
        i_valid = 1'b0;
    endtask

    int          ob_busy, ob_starts, ob_mids, ob_lasts, ob_ones, ob_rdy_busy;
    int          ob_first_mid, ob_first_rdy, ob_first_start;
    logic [15:0] ob_word;

    // Observe n clocks starting at word clock 0; optional i_nb_P change at clock chg_idx.
    task automatic observe(input int n, input int chg_idx, input int chg_nb);
        ob_busy = 0; ob_starts = 0; ob_mids = 0; ob_lasts = 0; ob_ones = 0; ob_rdy_busy = 0;
        ob_first_mid = -1; ob_first_rdy = -1; ob_first_start = -1; ob_word = '0;
        for (int i = 0; i < n; i++) begin
            if (o_busy) begin
                ob_busy++;
                if (o_ready) ob_rdy_busy++;
                if (o_ready && ob_first_rdy < 0) ob_first_rdy = i;
                if (o_chip) ob_ones++;
            end
            if (o_chip_start) begin
                if (ob_first_start < 0) ob_first_start = i;
                if (ob_starts < 16) ob_word[ob_starts] = o_chip;
                ob_starts++;
            end
            if (o_mid) begin
                if (ob_first_mid < 0) ob_first_mid = i;
                ob_mids++;
            end
            if (o_last) ob_lasts++;
            if (i == chg_idx) i_nb_P = CW'(chg_nb);
            wait_cycle();
            if (last_acc) i_valid = 1'b0;
        end
    endtask

    initial begin
        int tx_base, rx_base, nrx;
        i_rst = 1'b1; i_valid = 1'b0; i_data = '0; i_nb_P = '0;
        repeat (3) wait_cycle();
        lit("reset_outputs", int'({o_chip, o_chip_start, o_mid, o_last, o_busy, o_ready}), 0);
        i_rst = 1'b0;
        wait_cycle();
        lit("ready_after_reset", int'(o_ready), 1);

        // 0xA5 at 25 clocks per chip
        send(8'hA5, 25);
        observe(210, -1, 0);
        lit("t1_busy_clks", ob_busy, 200);
        lit("t1_word", int'(ob_word[7:0]), 8'hA5);
        lit("t1_starts", ob_starts, 8);
        lit("t1_mids", ob_mids, 8);
        lit("t1_first_mid", ob_first_mid, 12);
        lit("t1_last_clks", ob_lasts, 25);
        lit("t1_ready_in_busy", ob_rdy_busy, 1);

        // back-to-back 0x0F then 0xF0
        i_data = 8'h0F; i_nb_P = 25; i_valid = 1'b1;
        wait_acc();
        i_data = 8'hF0;
        observe(405, -1, 0);
        lit("t2_busy_clks", ob_busy, 400);
        lit("t2_first_ready", ob_first_rdy, 199);
        lit("t2_ready_in_busy", ob_rdy_busy, 2);
        lit("t2_chips", int'(ob_word), 16'hF00F);
        lit("t2_one_clks", ob_ones, 200);

        // nb_P below the minimum clamps to 4
        send(8'h01, 2);
        observe(40, -1, 0);
        lit("t3_busy_clks", ob_busy, 32);
        lit("t3_first_mid", ob_first_mid, 1);
        lit("t3_word", int'(ob_word[7:0]), 8'h01);

        // nb_P change mid-word only affects the next word
        send(8'hFF, 25);
        observe(205, 50, 10);
        lit("t4_busy_clks", ob_busy, 200);
        lit("t4_one_clks", ob_ones, 200);
        send(8'h3C, 10);
        observe(85, -1, 0);
        lit("t4_next_busy", ob_busy, 80);
        lit("t4_next_mid", ob_first_mid, 4);
        lit("t4_next_word", int'(ob_word[7:0]), 8'h3C);

        // reset 60 clocks into a word
        send(8'h5A, 25);
        observe(60, -1, 0);
        i_rst = 1'b1;
        wait_cycle();
        lit("t5_outputs_in_reset", int'({o_chip, o_chip_start, o_mid, o_last, o_ready}), 0);
        lit("t5_busy_in_reset", int'(o_busy), 0);
        i_rst = 1'b0;
        wait_cycle();
        lit("t5_ready_after", int'(o_ready), 1);
        send(8'h81, 6);
        observe(50, -1, 0);
        lit("t5_busy_clks", ob_busy, 48);
        lit("t5_first_start", ob_first_start, 0);
        lit("t5_word", int'(ob_word[7:0]), 8'h81);

        // random back-to-back loopback
        tx_base = tx_words.size();
        rx_base = rx_words.size();
        for (int w = 0; w < 1000; w++) begin
            send(DW'($urandom), int'($urandom_range(0, 8)));
        end
        repeat (600) wait_cycle();
        nrx = rx_words.size() - rx_base;
        lit("lb_word_count", nrx, 1000);
        for (int i = 0; i < 1000; i++) begin
            if (rx_base + i < rx_words.size() && tx_base + i < tx_words.size())
                lit("lb_word", int'(rx_words[rx_base + i]), int'(tx_words[tx_base + i]));
        end

        repeat (3) wait_cycle();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
